// File: rtl/adc_pkg.sv
// rtl/adc_pkg.sv - shared constants and types for the ADC128S022 responder emulator
package adc_pkg;

    localparam int         FRAME_LEN      = 16;
    localparam int         LEAD_ZEROS     = 4;
    localparam logic [3:0] ADDR_BIT_FIRST = 4'd2;
    localparam logic [3:0] ADDR_BIT_LAST  = 4'd4;
    localparam logic [3:0] LAST_BIT       = 4'(FRAME_LEN - 1);

    typedef logic [2:0] ch_addr_t;

    typedef enum logic {
        IDLE,
        FRAME
    } state_t;

endpackage

// File: rtl/adc128s022_emulator_if.sv
// rtl/adc128s022_emulator_if.sv - serial pins between an ADC controller and the emulated converter
interface adc128s022_emulator_if;

    logic adc_cs_n;
    logic adc_sck;
    logic din;
    logic dout;

    modport master (
        output adc_cs_n,
        output adc_sck,
        output din,
        input  dout
    );

    modport slave (
        input  adc_cs_n,
        input  adc_sck,
        input  din,
        output dout
    );

endinterface

// File: rtl/sync_edge_detect.sv
// rtl/sync_edge_detect.sv - input synchronizer chain with single-cycle rise/fall strobes
module sync_edge_detect #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] chain_q;
    logic              prev_q;

    // Chain clears to 0 so a CS already held low across reset never fakes a cs_fall.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            chain_q <= '0;
            prev_q  <= 1'b0;
        end else begin
            chain_q <= STAGES'({chain_q, d_i});
            prev_q  <= chain_q[STAGES-1];
        end
    end

    assign level_o = chain_q[STAGES-1];
    assign rise_o  = chain_q[STAGES-1] & ~prev_q;
    assign fall_o  = ~chain_q[STAGES-1] & prev_q;

endmodule

// File: rtl/adc128s022_emulator.sv
// rtl/adc128s022_emulator.sv - ADC128S022 serial responder returning parallel sample words as 16-bit frames
module adc128s022_emulator
    import adc_pkg::*;
#(
    parameter int NUM_CH      = 8,
    parameter int DATA_W      = 12,
    parameter int SYNC_STAGES = 2
) (
    input  logic                     clk_50,
    input  logic                     rst_n,
    adc128s022_emulator_if.slave     adc,
    input  logic [NUM_CH*DATA_W-1:0] ch_data,
    output ch_addr_t                 cur_ch,
    output logic                     frame_done
);

    logic cs_level, cs_rise, cs_fall;
    logic sck_level, sck_rise, sck_fall;
    logic din_level, din_rise, din_fall;

    sync_edge_detect #(.STAGES(SYNC_STAGES)) u_sync_cs (
        .clk     (clk_50),
        .rst_n   (rst_n),
        .d_i     (adc.adc_cs_n),
        .level_o (cs_level),
        .rise_o  (cs_rise),
        .fall_o  (cs_fall)
    );

    sync_edge_detect #(.STAGES(SYNC_STAGES)) u_sync_sck (
        .clk     (clk_50),
        .rst_n   (rst_n),
        .d_i     (adc.adc_sck),
        .level_o (sck_level),
        .rise_o  (sck_rise),
        .fall_o  (sck_fall)
    );

    sync_edge_detect #(.STAGES(SYNC_STAGES)) u_sync_din (
        .clk     (clk_50),
        .rst_n   (rst_n),
        .d_i     (adc.din),
        .level_o (din_level),
        .rise_o  (din_rise),
        .fall_o  (din_fall)
    );

    logic unused_sync;
    assign unused_sync = &{1'b0, cs_level, sck_level, din_rise, din_fall};

    logic [DATA_W-1:0] words [NUM_CH];

    for (genvar k = 0; k < NUM_CH; k++) begin : g_words
        assign words[k] = ch_data[k*DATA_W +: DATA_W];
    end

    state_t                 state_q;
    logic [3:0]             bit_idx_q;
    logic [FRAME_LEN-1:0]   shift_q;
    ch_addr_t               next_addr_q;
    ch_addr_t               cur_ch_q;
    logic                   frame_done_q;

    // cs edges are checked before sck edges, so CS activity always wins a same-cycle tie.
    always_ff @(posedge clk_50) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            next_addr_q  <= '0;
            cur_ch_q     <= '0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    bit_idx_q   <= '0;
                    shift_q     <= '0;
                    next_addr_q <= '0;
                    if (cs_fall) begin
                        state_q  <= FRAME;
                        shift_q  <= FRAME_LEN'(words[0]);
                        cur_ch_q <= '0;
                    end
                end
                FRAME: begin
                    if (cs_rise) begin
                        state_q     <= IDLE;
                        bit_idx_q   <= '0;
                        shift_q     <= '0;
                        next_addr_q <= '0;
                    end else begin
                        if (sck_rise && bit_idx_q >= ADDR_BIT_FIRST
                                     && bit_idx_q <= ADDR_BIT_LAST) begin
                            next_addr_q <= {next_addr_q[1:0], din_level};
                        end
                        if (sck_fall) begin
                            if (bit_idx_q == LAST_BIT) begin
                                // Address captured in this frame selects the sample of the next one.
                                bit_idx_q    <= '0;
                                shift_q      <= FRAME_LEN'(words[next_addr_q]);
                                cur_ch_q     <= next_addr_q;
                                frame_done_q <= 1'b1;
                            end else begin
                                bit_idx_q <= bit_idx_q + 4'd1;
                                shift_q   <= {shift_q[FRAME_LEN-2:0], 1'b0};
                            end
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign adc.dout   = shift_q[FRAME_LEN-1];
    assign cur_ch     = cur_ch_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_adc128s022_emulator.sv
// tb/tb_adc128s022_emulator.sv - scoreboard bench for the ADC128S022 responder emulator
module tb_adc128s022_emulator;
    import adc_pkg::*;

    logic        clk_50 = 1'b0;
    logic        rst_n  = 1'b0;
    logic [95:0] ch_data;
    logic [2:0]  cur_ch;
    logic        frame_done;
    logic [11:0] tb_data [8];

    int n_cmp  = 0;
    int n_bad  = 0;
    int fd_cnt = 0;
    logic [2:0] exp_ch = 3'd0;

    logic [15:0] exp_q [$];
    logic [2:0]  ch_q  [$];

    always #10 clk_50 = ~clk_50;

    adc128s022_emulator_if bus ();

    adc128s022_emulator dut (
        .clk_50     (clk_50),
        .rst_n      (rst_n),
        .adc        (bus),
        .ch_data    (ch_data),
        .cur_ch     (cur_ch),
        .frame_done (frame_done)
    );

    always_comb begin
        ch_data = '0;
        for (int k = 0; k < 8; k++) ch_data[k*12 +: 12] = tb_data[k];
    end

    always @(negedge clk_50) if (frame_done === 1'b1) fd_cnt++;

    task automatic half();
        repeat (10) @(negedge clk_50);
    endtask

    task automatic start_frame();
        @(negedge clk_50);
        bus.adc_cs_n = 1'b0;
        bus.din      = 1'($urandom_range(0, 1));
        exp_ch       = 3'd0;
        half();
    endtask

    task automatic end_frame();
        bus.adc_cs_n = 1'b1;
        repeat (12) @(negedge clk_50);
    endtask

    // Runs nbits SCK periods; the address goes out at bit positions 2..4, MSB first.
    task automatic clock_frame(input logic [2:0] addr, input int nbits,
                               input int change_bit, input logic [11:0] change_val);
        logic [15:0] got;
        logic [15:0] exp_w;
        logic [2:0]  exp_c;
        int          sh;
        got = '0;
        exp_q.push_back({4'h0, tb_data[exp_ch]});
        ch_q.push_back(exp_ch);
        for (int i = 0; i < nbits; i++) begin
            got[15-i] = bus.dout;
            if (i == 1) begin
                n_cmp++;
                if (cur_ch !== ch_q[$]) begin
                    n_bad++;
                    $display("FAIL cur_ch: got %0d want %0d", cur_ch, ch_q[$]);
                end
            end
            bus.adc_sck = 1'b1;
            if (i == change_bit) tb_data[0] = change_val;
            half();
            bus.adc_sck = 1'b0;
            bus.din = (i + 1 >= 2 && i + 1 <= 4) ? addr[3-i] : 1'($urandom_range(0, 1));
            half();
        end
        exp_w = exp_q.pop_front();
        exp_c = ch_q.pop_front();
        sh    = 16 - nbits;
        n_cmp++;
        if ((got >> sh) !== (exp_w >> sh)) begin
            n_bad++;
            $display("FAIL frame_word ch%0d: got %h want %h (%0d bits)", exp_c, got, exp_w, nbits);
        end
        if (nbits == 16) exp_ch = addr;
    endtask

    task automatic test_reset();
        bus.adc_cs_n = 1'b1;
        bus.adc_sck  = 1'b0;
        bus.din      = 1'b0;
        rst_n        = 1'b0;
        repeat (5) @(negedge clk_50);
        n_cmp++;
        if (bus.dout !== 1'b0 || cur_ch !== 3'd0 || frame_done !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_outputs: dout=%b cur_ch=%0d frame_done=%b want 0/0/0",
                     bus.dout, cur_ch, frame_done);
        end
        rst_n = 1'b1;
        repeat (8) @(negedge clk_50);
    endtask

    task automatic test_single_frame();
        int fd0;
        fd0 = fd_cnt;
        start_frame();
        clock_frame(3'b101, 16, -1, 12'h0);
        end_frame();
        n_cmp++;
        if (fd_cnt - fd0 !== 1) begin
            n_bad++;
            $display("FAIL single_frame_done: got %0d pulses want 1", fd_cnt - fd0);
        end
    endtask

    task automatic test_back_to_back();
        int fd0;
        fd0 = fd_cnt;
        start_frame();
        clock_frame(3'b101, 16, -1, 12'h0);
        clock_frame(3'b111, 16, -1, 12'h0);
        clock_frame(3'b000, 16, -1, 12'h0);
        end_frame();
        n_cmp++;
        if (fd_cnt - fd0 !== 3) begin
            n_bad++;
            $display("FAIL b2b_frame_done: got %0d pulses want 3", fd_cnt - fd0);
        end
    endtask

    task automatic test_rotation();
        logic [2:0] seq [6];
        int fd0;
        seq = '{3'd1, 3'd2, 3'd3, 3'd1, 3'd2, 3'd3};
        fd0 = fd_cnt;
        start_frame();
        for (int f = 0; f < 6; f++) clock_frame(seq[f], 16, -1, 12'h0);
        end_frame();
        n_cmp++;
        if (fd_cnt - fd0 !== 6) begin
            n_bad++;
            $display("FAIL rotation_frame_done: got %0d pulses want 6", fd_cnt - fd0);
        end
    endtask

    task automatic test_abort();
        int fd0;
        fd0 = fd_cnt;
        start_frame();
        clock_frame(3'b110, 7, -1, 12'h0);
        bus.adc_cs_n = 1'b1;
        repeat (6) @(negedge clk_50);
        n_cmp++;
        if (bus.dout !== 1'b0 || fd_cnt != fd0) begin
            n_bad++;
            $display("FAIL abort_idle: dout=%b pulses=%0d want 0/0", bus.dout, fd_cnt - fd0);
        end
        repeat (6) @(negedge clk_50);
        start_frame();
        clock_frame(3'b000, 16, -1, 12'h0);
        end_frame();
        n_cmp++;
        if (fd_cnt - fd0 !== 1) begin
            n_bad++;
            $display("FAIL abort_frame_done: got %0d pulses want 1", fd_cnt - fd0);
        end
    endtask

    task automatic test_snapshot();
        tb_data[0] = 12'hABC;
        start_frame();
        clock_frame(3'b000, 16, 6, 12'h555);
        end_frame();
        start_frame();
        clock_frame(3'b000, 16, -1, 12'h0);
        end_frame();
    endtask

    task automatic test_reset_mid_frame();
        int fd0;
        int ones;
        tb_data[0] = 12'hABC;
        start_frame();
        clock_frame(3'b011, 16, -1, 12'h0);
        clock_frame(3'b000, 5, -1, 12'h0);
        fd0 = fd_cnt;
        rst_n = 1'b0;
        @(negedge clk_50);
        rst_n = 1'b1;
        n_cmp++;
        if (bus.dout !== 1'b0 || cur_ch !== 3'd0 || dut.state_q !== IDLE) begin
            n_bad++;
            $display("FAIL reset_mid_frame: dout=%b cur_ch=%0d state=%0d want 0/0/IDLE",
                     bus.dout, cur_ch, dut.state_q);
        end
        ones = 0;
        half();
        for (int i = 0; i < 16; i++) begin
            if (bus.dout !== 1'b0) ones++;
            bus.adc_sck = 1'b1;
            half();
            bus.adc_sck = 1'b0;
            half();
        end
        n_cmp++;
        if (ones != 0 || fd_cnt != fd0) begin
            n_bad++;
            $display("FAIL no_frame_after_reset: nonzero_bits=%0d pulses=%0d want 0/0",
                     ones, fd_cnt - fd0);
        end
        end_frame();
        start_frame();
        clock_frame(3'b000, 16, -1, 12'h0);
        end_frame();
    endtask

    initial begin
        for (int k = 0; k < 8; k++) tb_data[k] = 12'h000;
        tb_data[0] = 12'hABC;
        tb_data[1] = 12'h3A1;
        tb_data[2] = 12'h5B2;
        tb_data[3] = 12'h7C3;
        tb_data[5] = 12'h123;
        tb_data[6] = 12'h9D6;
        tb_data[7] = 12'hFFF;
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_rotation();
        test_abort();
        test_snapshot();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
